// File: rtl/adder_bist_pkg.sv
// Shared types and defaults for the adder BIST controller and its expected-value pipe.
package adder_bist_pkg;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_LATENCY = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic                 valid;
    logic [DEF_WIDTH-1:0] a;
    logic [DEF_WIDTH-1:0] b;
    logic [DEF_WIDTH:0]   sum;
  } exp_entry_t;

endpackage

// File: rtl/adder_bist_exp_pipe.sv
// LATENCY-deep shift register of expected-result entries with a synchronous clear.
module adder_bist_exp_pipe
  import adder_bist_pkg::*;
#(
  parameter int  LATENCY = DEF_LATENCY,
  parameter type entry_t = exp_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   clear,
  input  entry_t din,
  output entry_t dout
);

  entry_t stages [LATENCY];

  // Shift one entry per clock; clear empties every stage at once.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < LATENCY; i++) begin
        stages[i] <= '0;
      end
    end else begin
      stages[0] <= din;
      for (int i = 1; i < LATENCY; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign dout = stages[LATENCY-1];

endmodule

// File: rtl/adder_bist.sv
// Exhaustive-sweep BIST controller for a registered adder with latency compensation.
// Optional macro ADDER_BIST_STOP_ON_FAIL_EN: end the sweep at the first mismatch.
module adder_bist
  import adder_bist_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   dut_a,
  output logic [WIDTH-1:0]   dut_b,
  input  logic [WIDTH:0]     dut_c,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   fail_count,
  output logic [WIDTH-1:0]   first_fail_a,
  output logic [WIDTH-1:0]   first_fail_b
);

  localparam int FCW = 2*WIDTH + 1;
  localparam int DCW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   sum;
  } entry_t;

  state_t           state;
  entry_t           push;
  entry_t           head;
  logic [DCW-1:0]   drain_cnt;
  logic             start_ok;
  logic             compare_en;
  logic             mismatch;
  logic             stop_hit;
  logic             last_pair;
  logic             drain_last;
  logic             pipe_clear;
  logic [FCW-1:0]   fail_next;

  always_comb begin
    push       = '0;
    push.valid = (state == RUN);
    push.a     = dut_a;
    push.b     = dut_b;
    push.sum   = {1'b0, dut_a} + {1'b0, dut_b};

    start_ok   = start && ((state == IDLE) || (state == DONE));
    compare_en = head.valid && ((state == RUN) || (state == DRAIN));
    mismatch   = compare_en && (dut_c != head.sum);

    if (mismatch && (fail_count != {FCW{1'b1}})) begin
      fail_next = fail_count + FCW'(1);
    end else begin
      fail_next = fail_count;
    end

    last_pair  = (dut_a == {WIDTH{1'b1}}) && (dut_b == {WIDTH{1'b1}});
    drain_last = (drain_cnt == DCW'(LATENCY - 1));
`ifdef ADDER_BIST_STOP_ON_FAIL_EN
    stop_hit   = mismatch;
`else
    stop_hit   = 1'b0;
`endif
    // A fresh sweep or an early stop must not see stale expectations.
    pipe_clear = start_ok || stop_hit;
  end

  adder_bist_exp_pipe #(
    .LATENCY (LATENCY),
    .entry_t (entry_t)
  ) u_exp_pipe (
    .clk   (clk),
    .rst   (rst),
    .clear (pipe_clear),
    .din   (push),
    .dout  (head)
  );

  // Sweep FSM, operand counters and failure bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      dut_a        <= '0;
      dut_b        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail_count   <= '0;
      first_fail_a <= '0;
      first_fail_b <= '0;
      drain_cnt    <= '0;
    end else begin
      if (mismatch) begin
        fail_count <= fail_next;
        if (fail_count == '0) begin
          first_fail_a <= head.a;
          first_fail_b <= head.b;
        end
      end

      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            state        <= RUN;
            busy         <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
            fail_count   <= '0;
            first_fail_a <= '0;
            first_fail_b <= '0;
            dut_a        <= '0;
            dut_b        <= '0;
          end
        end
        RUN, DRAIN: begin
          if (stop_hit || ((state == DRAIN) && drain_last)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (fail_next == '0);
            dut_a <= '0;
            dut_b <= '0;
          end else if (state == DRAIN) begin
            drain_cnt <= drain_cnt + DCW'(1);
          end else if (last_pair) begin
            state     <= DRAIN;
            drain_cnt <= '0;
            dut_a     <= '0;
            dut_b     <= '0;
          end else begin
            // b is the low half, so it wraps into a carry on a.
            {dut_a, dut_b} <= {dut_a, dut_b} + {{(2*WIDTH-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_bist.sv
// Bench for adder_bist: a LATENCY=1 and a LATENCY=2 instance against behavioural adders.
module tb_adder_bist;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a1, b1, a2, b2;
  logic [4:0] c1, c2;
  logic       busy1, done1, pass1, busy2, done2, pass2;
  logic [8:0] fc1, fc2;
  logic [3:0] ffa1, ffb1, ffa2, ffb2;

  // kind of adder behind dut1: 0 ideal 1-stage, 1 c[0] stuck at 0, 2 ideal 2-stage
  int kind = 0;
  logic [4:0] r1 = 5'd0, st1 = 5'd0, st2 = 5'd0, u1 = 5'd0, u2 = 5'd0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    r1  <= {1'b0, a1} + {1'b0, b1};
    st1 <= {1'b0, a1} + {1'b0, b1};
    st2 <= st1;
    u1  <= {1'b0, a2} + {1'b0, b2};
    u2  <= u1;
  end

  always_comb begin
    if (kind == 1)      c1 = {r1[4:1], 1'b0};
    else if (kind == 2) c1 = st2;
    else                c1 = r1;
  end
  assign c2 = u2;

  adder_bist #(.WIDTH(4), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .dut_a(a1), .dut_b(b1), .dut_c(c1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_count(fc1),
    .first_fail_a(ffa1), .first_fail_b(ffb1));

  adder_bist #(.WIDTH(4), .LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .dut_a(a2), .dut_b(b2), .dut_c(c2),
    .busy(busy2), .done(done2), .pass(pass2), .fail_count(fc2),
    .first_fail_a(ffa2), .first_fail_b(ffb2));

  typedef struct {
    int done_t;
    int fc;
    int ffa;
    int ffb;
  } res_t;

  // Whole-sweep outcome: the adder answers pair k with the sum of pair k-(depth-lat).
  function automatic res_t sweep_model(input int depth, input int lat, input bit stuck);
    res_t r;
    int e, g, j;
    r.done_t = 256 + lat;
    r.fc = 0; r.ffa = 0; r.ffb = 0;
    for (int k = 0; k < 256; k++) begin
      e = k / 16 + k % 16;
      j = k - (depth - lat);
      g = (j < 0) ? 0 : (j / 16 + j % 16);
      if (stuck) g = g & 30;
      if (g != e) begin
        if (r.fc == 0) begin
          r.ffa = k / 16;
          r.ffb = k % 16;
        end
        r.fc++;
`ifdef ADDER_BIST_STOP_ON_FAIL_EN
        r.done_t = k + 1 + lat;
        break;
`endif
      end
    end
    return r;
  endfunction

  int   m_t [2] = '{-1, -1};
  res_t m_r [2];

  // Model: t counts clock edges since the accepted start edge; -1 means idle after reset.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_t[d] <= -1;
      end else if (start && !(m_t[d] >= 0 && m_t[d] < m_r[d].done_t)) begin
        m_t[d] <= 0;
        m_r[d] <= sweep_model((d == 0) ? ((kind == 2) ? 2 : 1) : 2, d + 1, (d == 0) && (kind == 1));
      end else if (m_t[d] >= 0 && m_t[d] < 100000) begin
        m_t[d] <= m_t[d] + 1;
      end
    end
  end

  int checks = 0, errors = 0;
  bit chk_en = 1'b0;
  int lit_seq = 0, seen_seq = 0;
  int meas_dt1, meas_dt2, lit_dt1, lit_dt2, lit_fc1, lit_pass1, lit_ff1, lit_pass2;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_one(input int d, input logic bz, input logic dn, input logic ps,
                           input logic [8:0] fc, input logic [3:0] fa, input logic [3:0] fb,
                           input logic [3:0] da, input logic [3:0] db);
    int t, pair;
    res_t r;
    string s;
    t = m_t[d];
    r = m_r[d];
    s = $sformatf("dut%0d", d + 1);
    if (t < 0) begin
      chk({s, "_busy_idle"}, bz, 0);
      chk({s, "_done_idle"}, dn, 0);
      chk({s, "_pass_idle"}, ps, 0);
      chk({s, "_fc_idle"}, fc, 0);
      chk({s, "_ff_idle"}, {fa, fb}, 0);
      chk({s, "_ab_idle"}, {da, db}, 0);
    end else if (t < r.done_t) begin
      pair = (t < 256) ? t : 0;
      chk({s, "_busy_run"}, bz, 1);
      chk({s, "_done_run"}, dn, 0);
      chk({s, "_pass_run"}, ps, 0);
      chk({s, "_a_run"}, da, pair / 16);
      chk({s, "_b_run"}, db, pair % 16);
      if (t <= d + 1) begin
        chk({s, "_fc_cleared"}, fc, 0);
        chk({s, "_ff_cleared"}, {fa, fb}, 0);
      end
    end else begin
      chk({s, "_busy_done"}, bz, 0);
      chk({s, "_done_done"}, dn, 1);
      chk({s, "_pass_done"}, ps, (r.fc == 0) ? 1 : 0);
      chk({s, "_fc_done"}, fc, r.fc);
      chk({s, "_ffa_done"}, fa, r.ffa);
      chk({s, "_ffb_done"}, fb, r.ffb);
      chk({s, "_ab_done"}, {da, db}, 0);
    end
  endtask

  // Single compare process: model every cycle, plus hand-computed literals per sweep.
  always @(negedge clk) begin
    if (chk_en) begin
      check_one(0, busy1, done1, pass1, fc1, ffa1, ffb1, a1, b1);
      check_one(1, busy2, done2, pass2, fc2, ffa2, ffb2, a2, b2);
      if (lit_seq != seen_seq) begin
        seen_seq = lit_seq;
        chk("lit_done_cycle1", meas_dt1, lit_dt1);
        chk("lit_done_cycle2", meas_dt2, lit_dt2);
        chk("lit_fail_count1", fc1, lit_fc1);
        chk("lit_pass1", pass1, lit_pass1);
        chk("lit_first_fail1", {ffa1, ffb1}, lit_ff1);
        chk("lit_pass2", pass2, lit_pass2);
      end
    end
  end

  task automatic run_sweep(input int repulse_at, input int rst_at);
    meas_dt1 = -1;
    meas_dt2 = -1;
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      start = (cyc == repulse_at);
      rst   = (cyc == rst_at);
      if (done1 && meas_dt1 < 0) meas_dt1 = cyc;
      if (done2 && meas_dt2 < 0) meas_dt2 = cyc;
      if (meas_dt1 >= 0 && meas_dt2 >= 0) break;
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic post_lit(input int dt1, input int dt2, input int f1, input int p1,
                          input int ff1, input int p2);
    lit_dt1 = dt1; lit_dt2 = dt2; lit_fc1 = f1;
    lit_pass1 = p1; lit_ff1 = ff1; lit_pass2 = p2;
    lit_seq++;
    repeat (2) @(negedge clk);
  endtask

`ifdef ADDER_BIST_STOP_ON_FAIL_EN
  localparam int FAIL_DT = 3;
  localparam int STUCK_FC = 1;
  localparam int SKEW_FC = 1;
`else
  localparam int FAIL_DT = 257;
  localparam int STUCK_FC = 128;
  localparam int SKEW_FC = 255;
`endif

  initial begin
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    kind = 0;
    run_sweep(-1, -1);
    post_lit(257, 258, 0, 1, 0, 1);

    run_sweep(50, -1);
    post_lit(257, 258, 0, 1, 0, 1);

    kind = 1;
    run_sweep(-1, -1);
    post_lit(FAIL_DT, 258, STUCK_FC, 0, 8'h01, 1);

    kind = 2;
    run_sweep(-1, -1);
    post_lit(FAIL_DT, 258, SKEW_FC, 0, 8'h01, 1);

    kind = 0;
    run_sweep(-1, 100);
    post_lit(-1, -1, 0, 0, 0, 0);

    run_sweep(-1, -1);
    post_lit(257, 258, 0, 1, 0, 1);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_bist.md
Name: adder_bist

Overview:
- Built-in self-test controller for the registered 4-bit adder family.
- Drives an exhaustive operand sweep into the adder's a/b inputs and checks the returned sum c against the expected value, compensating for the adder's pipeline latency.
- Reports pass/fail, a failure count and the first failing operand pair.
- Sits beside the adder as its on-chip stimulus/check initiator; the adder is the responder.

Parameters:
- WIDTH, 4, operand width; dut_c width is WIDTH+1
- LATENCY, 1, adder clock latency from a/b change to c valid (legal range 1..4)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a sweep; sampled only in IDLE or DONE
- dut_a  output  WIDTH  operand A to the adder
- dut_b  output  WIDTH  operand B to the adder
- dut_c  input  WIDTH+1  sum returned by the adder
- busy  output  1  high in RUN and DRAIN
- done  output  1  high in DONE, held until the next start or rst
- pass  output  1  valid when done=1: 1 means fail_count==0
- fail_count  output  2*WIDTH+1  number of mismatching compares
- first_fail_a  output  WIDTH  operand A of the first mismatch
- first_fail_b  output  WIDTH  operand B of the first mismatch

Behaviour:
- Reset: all outputs 0 and state IDLE. This is the same in every state, so a reset mid-run aborts the sweep with no done.
- Clock and reset are decided as stated above: one clock, clk; reset rst, synchronous and active-high.
- States and transitions:
  - IDLE → RUN on start.
  - RUN → DRAIN after the last pair (a=b=2^WIDTH−1) is driven.
  - DRAIN → DONE after LATENCY cycles.
  - DONE → RUN on start.
- Starting a sweep: a start sampled at edge N clears fail_count, first_fail_a/b and pass. From cycle N+1, dut_a/dut_b=0/0.
- Sweep order: b is the inner counter, a the outer. b increments every cycle and wraps 2^WIDTH−1→0; when b wraps, a increments. Pair k is driven in cycle N+1+k, for k=0..2^(2*WIDTH)−1.
- Expected-value pipe: each driven pair pushes {valid, a, b, a+b} into a LATENCY-deep shift pipe. Sums are full WIDTH+1 bits; there is no truncation.
- Compare: at each edge where the pipe output is valid, dut_c is compared with the expected sum.
  - On mismatch, fail_count increments (saturating at all-ones).
  - If this is the first mismatch, first_fail_a/b capture the pipe's a/b.
- DRAIN: drives no new pairs; dut_a/dut_b return to 0. The pipe flushes its remaining entries, which are still compared.
- DONE: done=1, busy=0, pass=(fail_count==0). fail_count and first_fail_a/b are held.
- Sweep length: WIDTH=4, LATENCY=1 → done first visible in cycle N+258.
- start while busy: ignored.
- start and rst in the same cycle: rst wins.
- first_fail_a/b read 0 when there are no failures.

Optional Feature:
- Macro: ADDER_BIST_STOP_ON_FAIL_EN.
- When defined: the first mismatch forces an immediate transition to DONE, the pipe is flushed without further compares, fail_count=1 and pass=0.
- When not defined: the sweep always completes and counts all mismatches.

Decomposition:
- Package adder_bist_pkg holds:
  - state enum {IDLE, RUN, DRAIN, DONE}
  - the default WIDTH/LATENCY constants
  - the expected-entry struct {valid, a, b, sum}
- One sub-module: adder_bist_exp_pipe, a parameterised LATENCY-deep shift register of entries with a synchronous clear.
- The FSM, operand counters and compare/capture logic stay in the top module.

Test Plan:
- Ideal 1-cycle registered adder, WIDTH=4, LATENCY=1; start pulsed at edge N → busy from N+1, done=1 in cycle N+258, pass=1, fail_count=0, first_fail=0/0.
- Adder with c[0] stuck at 0 → fail_count=128, pass=0, first_fail_a=0, first_fail_b=1.
- LATENCY=2 with a 2-stage ideal adder → pass=1 and done one cycle later than the LATENCY=1 case. The same adder with LATENCY=1 configured → pass=0 and fail_count>0.
- start re-pulsed at cycle N+50 during RUN → no restart; results identical to the first test. start in DONE → a second sweep with identical results.
- rst asserted at cycle N+100 → next cycle all outputs 0, state IDLE, done stays 0; a later start gives a clean pass.
- With ADDER_BIST_STOP_ON_FAIL_EN and the c[0] stuck-at-0 adder → done shortly after pair (0,1) is compared, fail_count=1, first_fail=0/1, pass=0.
